// File: rtl/cone_pkg.sv
// cone_pkg: shared types and defaults for the cone deserializer.
// Optional feature macro: CONE_DESER_PARITY_EN adds a parity bit to each buffer entry.
package cone_pkg;
  localparam int CONE_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, FILL, STALL} cone_deser_state_e;
  typedef struct packed {
    logic [CONE_WIDTH_DEF-1:0] data;
    logic [$clog2(CONE_WIDTH_DEF+1)-1:0] len;
`ifdef CONE_DESER_PARITY_EN
    logic parity;
`endif
  } cone_entry_t;
endpackage

// File: rtl/cone_sync_fifo.sv
// cone_sync_fifo: DEPTH-entry synchronous FIFO (DEPTH a power of two).
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head entry),
// full, empty, level (current occupancy). Push while full is honoured only with a same-cycle pop.
module cone_sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign rdata = mem[rp];
  // Storage is cleared on reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/cone_deser_1to8.sv
// cone_deser_1to8: assembles the cone's serial result into WIDTH-bit words, LSB first, buffered.
// Ports: clk, rst_n (async active-low); in_bit/in_valid/in_ready serial input; flush pads and emits
// the partial word; out_data/out_len/out_valid/out_ready word output; overflow sticky dropped-flush flag.
// Optional macro CONE_DESER_PARITY_EN adds out_parity (XOR of the head word's valid bits).
module cone_deser_1to8
  import cone_pkg::*;
#(
  parameter int WIDTH = CONE_WIDTH_DEF,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_bit,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_len,
`ifdef CONE_DESER_PARITY_EN
  output logic                       out_parity,
`endif
  output logic                       overflow
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int LW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CW-1:0] len;
`ifdef CONE_DESER_PARITY_EN
    logic parity;
`endif
  } entry_t;
  cone_deser_state_e state;
  logic [CW-1:0] count, n_bits;
  logic [WIDTH-1:0] shreg, word;
  logic [LW-1:0] level, level_nxt;
  logic acc, push_req, push, pop, full, empty, drop, full_nxt;
  entry_t wr_entry, rd_entry;
  assign in_ready = state != STALL;
  assign acc = in_valid && in_ready;
  // Bits land at their final position; bits at and above count stay zero, which doubles as padding.
  assign word = shreg | (WIDTH'(acc & in_bit) << count);
  assign n_bits = count + CW'(acc);
  // A completing bit and a flush in the same cycle produce one full word, never an extra empty one.
  assign push_req = (n_bits == CW'(WIDTH)) || (flush && n_bits != '0);
  assign pop = out_valid && out_ready;
  assign push = push_req && (!full || pop);
  assign drop = push_req && !push;
  assign level_nxt = level + LW'(push) - LW'(pop);
  assign full_nxt = level_nxt == LW'(DEPTH);
  assign wr_entry.data = word;
  assign wr_entry.len = n_bits;
`ifdef CONE_DESER_PARITY_EN
  assign wr_entry.parity = ^word;
  assign out_parity = rd_entry.parity;
`endif
  assign out_valid = !empty;
  assign out_data = rd_entry.data;
  assign out_len = rd_entry.len;
  // STALL is decided from next-cycle count and occupancy, so in_ready is a pure register decode.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
      overflow <= 1'b0;
    end else begin
      state <= (push_req || n_bits == '0) ? IDLE :
               (n_bits == CW'(WIDTH-1) && full_nxt) ? STALL : FILL;
      count <= push_req ? '0 : n_bits;
      shreg <= push_req ? '0 : word;
      overflow <= overflow | drop;
    end
  cone_sync_fifo #(.DW($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .wdata(wr_entry),
    .pop(pop),
    .rdata(rd_entry),
    .full(full),
    .empty(empty),
    .level(level)
  );
endmodule

// File: tb/tb_cone_deser_1to8.sv
// tb_cone_deser_1to8: directed self-checking bench for cone_deser_1to8 (WIDTH=8, DEPTH=2).
module tb_cone_deser_1to8;
  logic clk = 1'b0;
  logic rst_n, in_bit, in_valid, in_ready, flush, out_valid, out_ready, overflow;
  logic [7:0] out_data;
  logic [3:0] out_len;
`ifdef CONE_DESER_PARITY_EN
  logic out_parity;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cone_deser_1to8 #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_len(out_len),
`ifdef CONE_DESER_PARITY_EN
    .out_parity(out_parity),
`endif
    .overflow(overflow)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_word(input logic [7:0] w, input int n, input logic fl);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit = w[i];
      flush = fl && (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_bit = 1'b0;
    flush = 1'b0;
  endtask
  initial begin
    rst_n = 1'b1;
    in_bit = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    send_word(8'h4D, 7, 1'b0);
    chk("full_pre_valid", out_valid, 0);
    send_word(8'h00, 1, 1'b0);
    chk("full_valid", out_valid, 1);
    chk("full_data", out_data, 8'h4D);
    chk("full_len", out_len, 8);
`ifdef CONE_DESER_PARITY_EN
    chk("full_parity", out_parity, 0);
`endif
    tick();
    chk("full_one_cycle", out_valid, 0);
    out_ready = 1'b0;
    send_word(8'h01, 8, 1'b0);
    send_word(8'h02, 8, 1'b0);
    send_word(8'h03, 7, 1'b0);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b1;
    in_bit = 1'b0;
    tick();
    tick();
    chk("bp_stall_held", in_ready, 0);
    chk("bp_head_stable", out_data, 8'h01);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_data", out_data, 8'h02);
    chk("bp_stall_exit", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_word3_data", out_data, 8'h03);
    chk("bp_word3_len", out_len, 8);
    chk("bp_word3_valid", out_valid, 1);
    tick();
    chk("bp_drained", out_valid, 0);
    send_word(8'h07, 3, 1'b0);
    chk("fp_no_early", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fp_valid", out_valid, 1);
    chk("fp_data", out_data, 8'h07);
    chk("fp_len", out_len, 3);
    send_word(8'hA5, 8, 1'b0);
    chk("fp_next_data", out_data, 8'hA5);
    chk("fp_next_len", out_len, 8);
    tick();
    send_word(8'h3C, 8, 1'b1);
    chk("f8_data", out_data, 8'h3C);
    chk("f8_len", out_len, 8);
    tick();
    chk("f8_no_extra", out_valid, 0);
    tick();
    chk("f8_no_extra2", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_noop", out_valid, 0);
    tick();
    chk("idle_flush_noop2", out_valid, 0);
    out_ready = 1'b0;
    send_word(8'h11, 8, 1'b0);
    send_word(8'h22, 8, 1'b0);
    send_word(8'h03, 2, 1'b0);
    chk("ov_before", overflow, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ov_set", overflow, 1);
    chk("ov_head", out_data, 8'h11);
    chk("ov_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("ov_drain_22", out_data, 8'h22);
    send_word(8'h5A, 8, 1'b0);
    chk("ov_count_cleared", out_data, 8'h5A);
    chk("ov_len", out_len, 8);
    chk("ov_sticky", overflow, 1);
    tick();
    chk("ov_drained", out_valid, 0);
    out_ready = 1'b0;
    send_word(8'h77, 8, 1'b0);
    send_word(8'h05, 3, 1'b0);
    chk("ar_buffered", out_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    chk("ar_out_len", out_len, 0);
    chk("ar_overflow", overflow, 0);
    chk("ar_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("ar_nothing", out_valid, 0);
    send_word(8'hA5, 8, 1'b0);
    chk("ar_a5_data", out_data, 8'hA5);
    chk("ar_a5_len", out_len, 8);
`ifdef CONE_DESER_PARITY_EN
    chk("ar_a5_parity", out_parity, 0);
`endif
    tick();
    send_word(8'h07, 3, 1'b1);
    chk("ar_f3_data", out_data, 8'h07);
    chk("ar_f3_len", out_len, 3);
`ifdef CONE_DESER_PARITY_EN
    chk("ar_f3_parity", out_parity, 1);
`endif
    tick();
    chk("ar_final_empty", out_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
